spike_fanout_dispatcher: RTL and testbench

Fan-out (target-side) dispatcher for the fan-IO neuron system; the writing end of the input spike FIFO that the fan-in controller drains. When a neuron fires, the block looks up that neuron's connection list (base pointer plus count) in the pointer memory. It streams the target addresses out of the connection memory and pushes them in order into the spike FIFO, honouring FIFO-full backpressure without losing in-flight reads.

---
 rtl/fanout_pkg.sv | 23 ++
 rtl/fanout_skid_buffer.sv | 53 +++++
 rtl/spike_fanout_dispatcher.sv | 161 ++++++++++++++++
 tb/tb_spike_fanout_dispatcher.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fanout_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fanout_pkg                                                           |
// | Shared widths and FSM state encoding for the fan-IO dispatch path.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fanout_pkg;

  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_PTR_WIDTH  = 16;
  localparam int DEF_CNT_WIDTH  = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PTR_FETCH = 3'd1,
    S_PTR_WAIT  = 3'd2,
    S_STREAM    = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } fanout_state_t;

endpackage
`default_nettype wire

// File: rtl/fanout_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fanout_skid_buffer                                                   |
// | DEPTH-entry synchronous FIFO holding returned connection targets.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fanout_skid_buffer #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spike_fanout_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spike_fanout_dispatcher                                              |
// | Streams a fired neuron's connection list into the spike FIFO.        |
// | Optional FANOUT_STATS_EN adds push and stall counters.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spike_fanout_dispatcher
  import fanout_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int PTR_WIDTH  = DEF_PTR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int RD_LATENCY = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fire_valid,
  input  logic [ADDR_WIDTH-1:0] i_fire_addr,
  output logic                  o_fire_ready,
  output logic                  o_ptr_mem_rden,
  output logic [ADDR_WIDTH-1:0] o_ptr_mem_addr,
  input  logic [PTR_WIDTH-1:0]  i_ptr_base,
  input  logic [CNT_WIDTH-1:0]  i_ptr_count,
  output logic                  o_conn_mem_rden,
  output logic [PTR_WIDTH-1:0]  o_conn_mem_addr,
  input  logic [ADDR_WIDTH-1:0] i_conn_target,
  output logic                  o_spike_fifo_wren,
  output logic [ADDR_WIDTH-1:0] o_spike_fifo_wdata,
  input  logic                  i_spike_fifo_full,
  output logic                  o_busy,
  output logic                  o_dispatch_done
`ifdef FANOUT_STATS_EN
  ,
  output logic [31:0]           o_stat_spikes,
  output logic [31:0]           o_stat_stall
`endif
);
  localparam int SKID_CW  = $clog2(SKID_DEPTH) + 1;
  localparam int WAIT_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int COMMIT_W = $clog2(SKID_DEPTH + RD_LATENCY + 1);

  fanout_state_t         state;
  fanout_state_t         state_nxt;
  logic [ADDR_WIDTH-1:0] neuron;
  logic [PTR_WIDTH-1:0]  conn_addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [RD_LATENCY:0]   vld_ext;
  logic [COMMIT_W-1:0]   in_flight;
  logic [COMMIT_W-1:0]   committed;
  logic [SKID_CW-1:0]    skid_count;
  logic [ADDR_WIDTH-1:0] skid_head;
  logic                  skid_empty;
  logic                  rd_return;
  logic                  issue;
  logic                  pop;
  logic                  wait_last;

  assign wait_last = (wait_cnt == WAIT_W'(RD_LATENCY - 1));
  assign vld_ext   = {vld_pipe, issue};
  assign rd_return = vld_pipe[RD_LATENCY-1];

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + COMMIT_W'(vld_pipe[i]);
    end
  end

  // Credits count reads still in the pipe plus entries already buffered,
  // so a return can always be written without checking for space.
  assign committed = in_flight + COMMIT_W'(skid_count);
  assign issue     = (state == S_STREAM) && (remaining != '0) &&
                     (committed < COMMIT_W'(SKID_DEPTH));
  assign pop       = !skid_empty && !i_spike_fifo_full;

  assign o_fire_ready       = (state == S_IDLE);
  assign o_busy             = (state != S_IDLE);
  assign o_dispatch_done    = (state == S_DONE);
  assign o_ptr_mem_rden     = (state == S_PTR_FETCH);
  assign o_ptr_mem_addr     = neuron;
  assign o_conn_mem_rden    = issue;
  assign o_conn_mem_addr    = conn_addr;
  assign o_spike_fifo_wren  = pop;
  assign o_spike_fifo_wdata = skid_empty ? '0 : skid_head;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (i_fire_valid) state_nxt = S_PTR_FETCH;
      S_PTR_FETCH: state_nxt = S_PTR_WAIT;
      S_PTR_WAIT:  if (wait_last) state_nxt = (i_ptr_count == '0) ? S_DONE : S_STREAM;
      S_STREAM:    if (issue && remaining == CNT_WIDTH'(1)) state_nxt = S_DRAIN;
      // Leave once the final entry is being popped so done follows the last push.
      S_DRAIN:     if (in_flight == '0 &&
                       (skid_empty || (skid_count == SKID_CW'(1) && pop)))
                     state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neuron    <= '0;
      conn_addr <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      vld_pipe  <= '0;
    end else begin
      vld_pipe <= vld_ext[RD_LATENCY-1:0];
      if (o_fire_ready && i_fire_valid) neuron <= i_fire_addr;
      if (state == S_PTR_WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                     wait_cnt <= '0;
      if (state == S_PTR_WAIT && wait_last) begin
        conn_addr <= i_ptr_base;
        remaining <= i_ptr_count;
      end else if (issue) begin
        conn_addr <= conn_addr + PTR_WIDTH'(1);
        remaining <= remaining - CNT_WIDTH'(1);
      end
    end
  end

  fanout_skid_buffer #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_return),
    .push_data (i_conn_target),
    .pop       (pop),
    .head      (skid_head),
    .count     (skid_count),
    .empty     (skid_empty)
  );

`ifdef FANOUT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stat_spikes <= '0;
      o_stat_stall  <= '0;
    end else begin
      if (pop && o_stat_spikes != '1) o_stat_spikes <= o_stat_spikes + 32'd1;
      if (!skid_empty && i_spike_fifo_full && o_stat_stall != '1)
        o_stat_stall <= o_stat_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spike_fanout_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spike_fanout_dispatcher                                           |
// | Directed bench with two-cycle-latency pointer/connection memories.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_spike_fanout_dispatcher;
  localparam int AW = 14;
  localparam int PW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fire_valid;
  logic [AW-1:0] fire_addr;
  logic          fire_ready;
  logic          ptr_rden;
  logic [AW-1:0] ptr_addr;
  logic [PW-1:0] ptr_base;
  logic [CW-1:0] ptr_count;
  logic          conn_rden;
  logic [PW-1:0] conn_addr;
  logic [AW-1:0] conn_target;
  logic          wren;
  logic [AW-1:0] wdata;
  logic          full;
  logic          busy;
  logic          done;
`ifdef FANOUT_STATS_EN
  logic [31:0]   stat_spikes;
  logic [31:0]   stat_stall;
`endif

  always #5 clk = ~clk;

  spike_fanout_dispatcher dut (
    .clk                (clk),
    .rst                (rst),
    .i_fire_valid       (fire_valid),
    .i_fire_addr        (fire_addr),
    .o_fire_ready       (fire_ready),
    .o_ptr_mem_rden     (ptr_rden),
    .o_ptr_mem_addr     (ptr_addr),
    .i_ptr_base         (ptr_base),
    .i_ptr_count        (ptr_count),
    .o_conn_mem_rden    (conn_rden),
    .o_conn_mem_addr    (conn_addr),
    .i_conn_target      (conn_target),
    .o_spike_fifo_wren  (wren),
    .o_spike_fifo_wdata (wdata),
    .i_spike_fifo_full  (full),
    .o_busy             (busy),
    .o_dispatch_done    (done)
`ifdef FANOUT_STATS_EN
    ,
    .o_stat_spikes      (stat_spikes),
    .o_stat_stall       (stat_stall)
`endif
  );

  function automatic logic [CW+PW-1:0] ptr_fn(input logic [AW-1:0] a);
    case (a)
      14'd1:   return {8'd3, 16'h0100};
      14'd2:   return {8'd0, 16'h0400};
      14'd3:   return {8'd8, 16'h0200};
      14'd4:   return {8'd4, 16'hFFFE};
      14'd5:   return {8'd6, 16'h0300};
      default: return '0;
    endcase
  endfunction

  function automatic logic [AW-1:0] conn_fn(input logic [PW-1:0] a);
    case (a)
      16'h0100: return 14'h0011;
      16'h0101: return 14'h0022;
      16'h0102: return 14'h0033;
      default:  return a[AW-1:0] ^ 14'h2A5A;
    endcase
  endfunction

  // Two-cycle read latency memories; non-read cycles return poison values.
  logic [CW+PW-1:0] pq1, pq2;
  logic [AW-1:0]    cq1, cq2;
  always @(posedge clk) begin
    pq1 <= ptr_rden ? ptr_fn(ptr_addr) : '0;
    pq2 <= pq1;
    cq1 <= conn_rden ? conn_fn(conn_addr) : 14'h3FFF;
    cq2 <= cq1;
  end
  assign {ptr_count, ptr_base} = pq2;
  assign conn_target = cq2;

  int            cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] push_q[$];
  int            pcyc_q[$];
  logic [PW-1:0] conn_q[$];
  int            acc_cyc, ptr_cyc, done_cyc, done_n, wren_full;
  int            issued, pushed, max_commit;
  logic [AW-1:0] ptr_a;

  initial begin
    acc_cyc = 0; ptr_cyc = 0; done_cyc = 0; done_n = 0; wren_full = 0;
    issued = 0; pushed = 0; max_commit = 0; ptr_a = '0;
  end

  always @(negedge clk) begin
    if (fire_valid && fire_ready) acc_cyc <= cyc;
    if (ptr_rden) begin
      ptr_cyc <= cyc;
      ptr_a   <= ptr_addr;
    end
    if (conn_rden) conn_q.push_back(conn_addr);
    if (wren) begin
      push_q.push_back(wdata);
      pcyc_q.push_back(cyc);
      if (full) wren_full <= wren_full + 1;
    end
    if (done) begin
      done_cyc <= cyc;
      done_n   <= done_n + 1;
    end
    if (rst) begin
      issued <= 0;
      pushed <= 0;
    end else begin
      if (issued - pushed + int'(conn_rden) > max_commit)
        max_commit <= issued - pushed + int'(conn_rden);
      issued <= issued + int'(conn_rden);
      pushed <= pushed + int'(wren);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fire(input logic [AW-1:0] a);
    int n = 0;
    @(posedge clk); #1;
    while (!fire_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fire_ready_wait", 32'(fire_ready), 32'd1);
    fire_valid = 1'b1;
    fire_addr  = a;
    @(posedge clk); #1;
    fire_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_n == prev && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done_n != prev), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, c0, d0, f0, np;
    logic [AW-1:0] exp_a [3];
    logic [PW-1:0] exp_wa [4];
    logic [AW-1:0] exp_wd [4];
    exp_a  = '{14'h0011, 14'h0022, 14'h0033};
    exp_wa = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_wd = '{14'h15A4, 14'h15A5, 14'h2A5A, 14'h2A5B};
    rst = 1'b1; fire_valid = 1'b0; fire_addr = '0; full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(fire_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_ptr_rden", 32'(ptr_rden), 32'd0);
    chk("rst_conn_rden", 32'(conn_rden), 32'd0);

    // Three-entry list, no backpressure.
    p0 = push_q.size(); c0 = conn_q.size(); d0 = done_n;
    fire(14'd1);
    wait_done(d0);
    chk("A_ptr_cyc", 32'(ptr_cyc - acc_cyc), 32'd1);
    chk("A_ptr_addr", 32'(ptr_a), 32'd1);
    chk("A_conn0", 32'(conn_q[c0]), 32'h0100);
    np = push_q.size() - p0;
    chk("A_npush", 32'(np), 32'd3);
    for (int i = 0; i < 3 && i < np; i++) begin
      chk("A_data", 32'(push_q[p0+i]), 32'(exp_a[i]));
      chk("A_pcyc", 32'(pcyc_q[p0+i] - acc_cyc), 32'(7 + i));
    end
    chk("A_done_cyc", 32'(done_cyc - acc_cyc), 32'd10);

    // Empty list.
    p0 = push_q.size(); c0 = conn_q.size(); d0 = done_n;
    fire(14'd2);
    wait_done(d0);
    chk("B_nconn", 32'(conn_q.size() - c0), 32'd0);
    chk("B_npush", 32'(push_q.size() - p0), 32'd0);
    chk("B_done_cyc", 32'(done_cyc - acc_cyc), 32'd4);
    @(negedge clk);
    chk("B_ready", 32'(fire_ready), 32'd1);

    // Connection address wraps past 0xFFFF.
    p0 = push_q.size(); c0 = conn_q.size(); d0 = done_n;
    fire(14'd4);
    wait_done(d0);
    chk("D_nconn", 32'(conn_q.size() - c0), 32'd4);
    chk("D_npush", 32'(push_q.size() - p0), 32'd4);
    for (int i = 0; i < 4 && c0 + i < conn_q.size(); i++)
      chk("D_addr", 32'(conn_q[c0+i]), 32'(exp_wa[i]));
    for (int i = 0; i < 4 && p0 + i < push_q.size(); i++)
      chk("D_data", 32'(push_q[p0+i]), 32'(exp_wd[i]));
    chk("D_done_cyc", 32'(done_cyc - acc_cyc), 32'd11);

    // Reset during the third stream cycle.
    c0 = conn_q.size(); d0 = done_n;
    fire(14'd5);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("E_ready", 32'(fire_ready), 32'd1);
    chk("E_busy", 32'(busy), 32'd0);
    chk("E_ptr_rden", 32'(ptr_rden), 32'd0);
    chk("E_conn_rden", 32'(conn_rden), 32'd0);
    chk("E_conn_addr", 32'(conn_addr), 32'd0);
    chk("E_ptr_addr", 32'(ptr_addr), 32'd0);
    chk("E_wren", 32'(wren), 32'd0);
    chk("E_wdata", 32'(wdata), 32'd0);
    chk("E_done", 32'(done), 32'd0);
    p0 = push_q.size();
    repeat (10) @(negedge clk);
    #1;
    chk("E_nconn", 32'(conn_q.size() - c0), 32'd3);
    chk("E_stale_push", 32'(push_q.size() - p0), 32'd0);
    chk("E_no_done", 32'(done_n - d0), 32'd0);

    // Eight entries with the FIFO full for five cycles from the first push.
    p0 = push_q.size(); c0 = conn_q.size(); d0 = done_n; f0 = wren_full;
    fire(14'd3);
    repeat (6) @(posedge clk);
    #1 full = 1'b1;
    repeat (5) @(posedge clk);
    #1 full = 1'b0;
    wait_done(d0);
    np = push_q.size() - p0;
    chk("C_npush", 32'(np), 32'd8);
    chk("C_nconn", 32'(conn_q.size() - c0), 32'd8);
    for (int i = 0; i < 8 && i < np; i++)
      chk("C_data", 32'(push_q[p0+i]), 32'(conn_fn(16'h0200 + 16'(i))));
    if (np == 8) begin
      chk("C_first_push", 32'(pcyc_q[p0] - acc_cyc), 32'd12);
      chk("C_last_push", 32'(pcyc_q[p0+7] - acc_cyc), 32'd19);
    end
    chk("C_done_cyc", 32'(done_cyc - acc_cyc), 32'd20);
    chk("C_wren_full", 32'(wren_full - f0), 32'd0);
    chk("C_max_commit", 32'(max_commit), 32'd4);
`ifdef FANOUT_STATS_EN
    chk("C_stat_spikes", stat_spikes, 32'd8);
    chk("C_stat_stall", stat_stall, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
